// File: rtl/iccm_uart_loader_if.sv
// ICCM write-port bundle driven by the UART boot loader.
//   o_address   : ICCM word address (holds between writes)
//   o_write     : one-cycle write strobe per word
//   o_data      : ICCM write data (holds the last written word)
//   o_core_hold : high while the core must stay in reset
//   o_done      : sticky, image fully loaded
//   o_error     : sticky, load aborted
// master = loader side, slave = ICCM / core side.
interface iccm_uart_loader_if #(
    parameter int AddrWidth = 10,
    parameter int DataWidth = 32
);
    logic [AddrWidth-1:0] o_address;
    logic                 o_write;
    logic [DataWidth-1:0] o_data;
    logic                 o_core_hold;
    logic                 o_done;
    logic                 o_error;

    modport master (
        output o_address, o_write, o_data, o_core_hold, o_done, o_error
    );

    modport slave (
        input o_address, o_write, o_data, o_core_hold, o_done, o_error
    );
endinterface

// File: rtl/iccm_uart_loader.sv
// Boot-time ICCM loader: receives a program image over an 8N1 UART line,
// writes it word by word into the ICCM and keeps the core in reset until
// the whole image is in place.
// Image format: 4-byte little-endian word count N, then N words, each
// 4 bytes little-endian.
// Ports:
//   clock   : system clock, rising edge
//   reset_n : asynchronous active-low reset
//   rx      : UART serial input, idle high, asynchronous to clock
//   bus     : ICCM write port and status (iccm_uart_loader_if.master)
module iccm_uart_loader #(
    parameter int DataWidth  = 32,
    parameter int AddrWidth  = 10,
    parameter int ClksPerBit = 868
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   rx,
    iccm_uart_loader_if.master     bus
);

    localparam int Depth   = 1 << AddrWidth;
    localparam int IdxW    = AddrWidth + 1;
    localparam int CntW    = $clog2(ClksPerBit);
    localparam int HalfBit = ClksPerBit / 2;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    typedef enum logic [2:0] {
        S_LEN,
        S_DATA,
        S_WRITE,
        S_DONE,
        S_ERR
    } state_t;

    logic           rx_meta;
    logic           rx_sync;
    logic           rx_prev;

    rx_state_t      rx_state;
    rx_state_t      rx_next;
    logic [CntW-1:0] clk_cnt;
    logic [2:0]     bit_idx;
    logic [7:0]     rx_shift;
    logic           half_done;
    logic           bit_done;
    logic           byte_valid;
    logic           frame_err;

    state_t         state;
    state_t         state_next;
    logic [1:0]     byte_cnt;
    logic [31:0]    shift_q;
    logic [31:0]    assembled;
    logic [IdxW-1:0] word_count;
    logic [IdxW-1:0] index;
    logic [DataWidth-1:0] data_q;
    logic           last_word;

    // rx_prev is a third stage used only to spot the falling start edge.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    assign half_done = (clk_cnt == CntW'(HalfBit - 1));
    assign bit_done  = (clk_cnt == CntW'(ClksPerBit - 1));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rx_state <= RX_IDLE;
        end else begin
            rx_state <= rx_next;
        end
    end

    // byte_valid / frame_err are single-cycle pulses at the stop-bit sample.
    always_comb begin
        rx_next    = rx_state;
        byte_valid = 1'b0;
        frame_err  = 1'b0;
        unique case (rx_state)
            RX_IDLE: begin
                if (rx_prev && !rx_sync) begin
                    rx_next = RX_START;
                end
            end
            RX_START: begin
                if (half_done) begin
                    rx_next = rx_sync ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (bit_done && (bit_idx == 3'd7)) begin
                    rx_next = RX_STOP;
                end
            end
            RX_STOP: begin
                if (bit_done) begin
                    rx_next = RX_IDLE;
                    if (rx_sync) begin
                        byte_valid = 1'b1;
                    end else begin
                        frame_err = 1'b1;
                    end
                end
            end
            default: rx_next = RX_IDLE;
        endcase
    end

    // The counter restarts at the start-bit mid-sample, so every later
    // sample lands in the middle of its bit.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            clk_cnt  <= '0;
            bit_idx  <= '0;
            rx_shift <= '0;
        end else begin
            unique case (rx_state)
                RX_IDLE: begin
                    clk_cnt <= '0;
                    bit_idx <= '0;
                end
                RX_START: begin
                    clk_cnt <= half_done ? '0 : clk_cnt + 1'b1;
                end
                RX_DATA: begin
                    if (bit_done) begin
                        clk_cnt  <= '0;
                        bit_idx  <= bit_idx + 1'b1;
                        rx_shift <= {rx_sync, rx_shift[7:1]};
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                RX_STOP: begin
                    clk_cnt <= bit_done ? '0 : clk_cnt + 1'b1;
                end
                default: clk_cnt <= '0;
            endcase
        end
    end

    // Newest byte enters at the top, so after four bytes the first one
    // sits in bits [7:0].
    assign assembled = {rx_shift, shift_q[31:8]};
    assign last_word = (index == word_count - IdxW'(1));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_LEN;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            S_LEN: begin
                if (frame_err) begin
                    state_next = S_ERR;
                end else if (byte_valid && (byte_cnt == 2'd3)) begin
                    if (assembled == 32'd0) begin
                        state_next = S_DONE;
                    end else if (assembled > 32'(Depth)) begin
                        state_next = S_ERR;
                    end else begin
                        state_next = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (frame_err) begin
                    state_next = S_ERR;
                end else if (byte_valid && (byte_cnt == 2'd3)) begin
                    state_next = S_WRITE;
                end
            end
            S_WRITE: begin
                if (frame_err) begin
                    state_next = S_ERR;
                end else begin
                    state_next = last_word ? S_DONE : S_DATA;
                end
            end
            S_DONE:  state_next = S_DONE;
            S_ERR:   state_next = S_ERR;
            default: state_next = S_ERR;
        endcase
    end

    // byte_cnt wraps modulo 4, so it is already 0 at every word boundary.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            byte_cnt   <= '0;
            shift_q    <= '0;
            word_count <= '0;
            index      <= '0;
            data_q     <= '0;
        end else begin
            if (byte_valid && ((state == S_LEN) || (state == S_DATA))) begin
                shift_q  <= assembled;
                byte_cnt <= byte_cnt + 1'b1;
            end
            if ((state == S_LEN) && (state_next == S_DATA)) begin
                word_count <= assembled[IdxW-1:0];
            end
            if ((state == S_DATA) && (state_next == S_WRITE)) begin
                data_q <= assembled;
            end
            if ((state == S_WRITE) && (state_next == S_DATA)) begin
                index <= index + 1'b1;
            end
        end
    end

    assign bus.o_address   = index[AddrWidth-1:0];
    assign bus.o_data      = data_q;
    assign bus.o_write     = (state == S_WRITE);
    assign bus.o_done      = (state == S_DONE);
    assign bus.o_core_hold = (state != S_DONE);
    assign bus.o_error     = (state == S_ERR);

endmodule
